// File: rtl/seg_mux_ctrl.sv
// Two-digit multiplexed 7-segment driver: per-digit blank/show slots, frame-start snapshot
// of the hex inputs, and registered active-low segment and anode outputs.
module seg_mux_ctrl #(
  parameter int DIV   = 20000,
  parameter int BLANK = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] C_DIV_LAST   = CW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BLANK0 = 3'd1,
    ST_SHOW0  = 3'd2,
    ST_BLANK1 = 3'd3,
    ST_SHOW1  = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_snap0;
  logic [3:0]    r_snap1;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_frame_start;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Next state: the slot counter free-runs 0..DIV-1 and the state only picks which half of the slot we are in.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt == C_DIV_LAST) ? {CW{1'b0}} : r_cnt + CW'(1);
    w_frame_start = 1'b0;
    if (!en) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = {CW{1'b0}};
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt   = ST_BLANK0;
          w_cnt_nxt     = {CW{1'b0}};
          w_frame_start = 1'b1;
        end
        ST_BLANK0: begin
          if (r_cnt == C_BLANK_LAST) w_state_nxt = ST_SHOW0;
          else                       w_state_nxt = ST_BLANK0;
        end
        ST_SHOW0: begin
          if (r_cnt == C_DIV_LAST) w_state_nxt = ST_BLANK1;
          else                     w_state_nxt = ST_SHOW0;
        end
        ST_BLANK1: begin
          if (r_cnt == C_BLANK_LAST) w_state_nxt = ST_SHOW1;
          else                       w_state_nxt = ST_BLANK1;
        end
        ST_SHOW1: begin
          if (r_cnt == C_DIV_LAST) begin
            w_state_nxt   = ST_BLANK0;
            w_frame_start = 1'b1;
          end else begin
            w_state_nxt   = ST_SHOW1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the pins line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_OFF;
      r_cnt      <= {CW{1'b0}};
      r_snap0    <= 4'h0;
      r_snap1    <= 4'h0;
      an         <= 2'b11;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_snap0 <= s0;
        r_snap1 <= s1;
      end else begin
        r_snap0 <= r_snap0;
        r_snap1 <= r_snap1;
      end
      case (w_state_nxt)
        ST_SHOW0: begin
          an  <= 2'b10;
          seg <= hex_to_seg(r_snap0);
        end
        ST_SHOW1: begin
          an  <= 2'b01;
          seg <= hex_to_seg(r_snap1);
        end
        default: begin
          an  <= 2'b11;
          seg <= 7'h7F;
        end
      endcase
    end
  end

endmodule
